// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: turns the PS/2 byte stream (E0/F0 prefixes + code) into held key events.
// Define PS2_EXT_EN to decode E0-prefixed extended keys; otherwise 0xE0 is consumed and ignored.
module ps2_scan_ctrl #(
  parameter int TIMEOUT = 25000,
  parameter int TW      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_done,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       err
);

`ifdef PS2_EXT_EN
  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_HOLD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_F0, S_HOLD} state_t;
`endif

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_cnt;
  logic [7:0]    r_code;
  logic          r_brk;
  logic          w_pop;
  logic          w_prefix;
  logic          w_expire;
  logic          w_err;
  logic          w_load;
  logic          w_brk;
  logic          w_is_e0;
  logic          w_is_f0;
  logic          w_is_bad;
`ifdef PS2_EXT_EN
  logic          w_ext;
  logic          r_ext;
`endif

  assign w_pop    = rx_rdy && (r_state != S_HOLD);
  assign w_is_e0  = (rx_data == 8'hE0);
  assign w_is_f0  = (rx_data == 8'hF0);
  assign w_is_bad = (rx_data == 8'h00) || (rx_data == 8'hFF);
  assign w_prefix = (r_state != S_IDLE) && (r_state != S_HOLD);
  assign w_expire = w_prefix && (r_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_load = 1'b0;
    w_brk  = 1'b0;
`ifdef PS2_EXT_EN
    w_ext  = 1'b0;
`endif
    if (r_state == S_HOLD) begin
      if (ev_ready) w_next = S_IDLE;
    end else if (w_pop) begin
      if (w_is_bad) begin
        w_err  = 1'b1;
        w_next = S_IDLE;
      end else if (w_is_e0) begin
`ifdef PS2_EXT_EN
        // E0 restarts an extended sequence; after F0 it is out of order
        w_next = S_E0;
        w_err  = (r_state == S_F0) || (r_state == S_E0F0);
`else
        w_next = r_state;
`endif
      end else if (w_is_f0) begin
        case (r_state)
          S_IDLE:  w_next = S_F0;
`ifdef PS2_EXT_EN
          S_E0:    w_next = S_E0F0;
`endif
          default: w_err = 1'b1;
        endcase
      end else begin
        w_load = 1'b1;
        w_next = S_HOLD;
`ifdef PS2_EXT_EN
        w_brk  = (r_state == S_F0) || (r_state == S_E0F0);
        w_ext  = (r_state == S_E0) || (r_state == S_E0F0);
`else
        w_brk  = (r_state == S_F0);
`endif
      end
    end else if (w_expire) begin
      w_err  = 1'b1;
      w_next = S_IDLE;
    end
  end

  always_comb begin
    rx_done  = 1'b0;
    ev_valid = 1'b0;
    err      = 1'b0;
    if (!rst) begin
      rx_done  = w_pop;
      ev_valid = (r_state == S_HOLD);
      err      = w_err;
    end
  end

  // Prefix-wait timer: runs only while a prefix is pending and no byte arrives
  always_ff @(posedge clk) begin
    if (rst || !w_prefix || w_pop || w_expire) r_cnt <= '0;
    else                                       r_cnt <= r_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code <= 8'h00;
      r_brk  <= 1'b0;
    end else if (w_load) begin
      r_code <= rx_data;
      r_brk  <= w_brk;
    end
  end

`ifdef PS2_EXT_EN
  always_ff @(posedge clk) begin
    if (rst)         r_ext <= 1'b0;
    else if (w_load) r_ext <= w_ext;
  end
  assign ev_ext = r_ext;
`else
  assign ev_ext = 1'b0;
`endif

  assign ev_code  = r_code;
  assign ev_break = r_brk;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: directed scenarios plus a randomized byte stream
// checked cycle by cycle against a prefix-flag reference model.
module tb_ps2_scan_ctrl;

  localparam int TO = 40;
`ifdef PS2_EXT_EN
  localparam logic EXT = 1'b1;
`else
  localparam logic EXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       ev_ready = 1'b0;
  logic       rx_done;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  logic d, e;

  always #5 clk = ~clk;

  ps2_scan_ctrl #(.TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_done(rx_done),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_break(ev_break),
    .ev_ext(ev_ext), .err(err)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Present one byte for one cycle, capturing the pop strobe and err seen in that cycle
  task automatic send(input logic [7:0] b, output logic done_s, output logic err_s);
    rx_rdy = 1'b1; rx_data = b; #1;
    done_s = rx_done; err_s = err;
    @(posedge clk); #1;
    rx_rdy = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'hFF; ev_ready = 1'b1;
    repeat (3) tick();
    n_tests++; if (rx_done !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_done: got %0b expected 0", rx_done); end
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %0b expected 0", ev_valid); end
    n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %0b expected 0", err); end
    n_tests++; if (ev_code !== 8'h00) begin n_fail++; $display("FAIL reset_ev_code: got %0h expected 00", ev_code); end
    n_tests++; if (ev_break !== 1'b0) begin n_fail++; $display("FAIL reset_ev_break: got %0b expected 0", ev_break); end
    n_tests++; if (ev_ext !== 1'b0)   begin n_fail++; $display("FAIL reset_ev_ext: got %0b expected 0", ev_ext); end
    rx_rdy = 1'b0; rst = 1'b0; ev_ready = 1'b0;
    tick();
    n_tests++; if (ev_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got valid=%0b err=%0b expected 0/0", ev_valid, err); end
  endtask

  task automatic test_press();
    ev_ready = 1'b1; rx_rdy = 1'b1; rx_data = 8'h1C; #1;
    n_tests++; if (rx_done !== 1'b1)  begin n_fail++; $display("FAIL press_pop: got %0b expected 1", rx_done); end
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL press_valid_early: got %0b expected 0", ev_valid); end
    @(posedge clk); #1; rx_rdy = 1'b0; #1;
    n_tests++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL press_latency: got valid=%0b expected 1", ev_valid); end
    n_tests++; if ({ev_code, ev_break, ev_ext} !== {8'h1C, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL press_event: got %0h/%0b/%0b expected 1c/0/0", ev_code, ev_break, ev_ext); end
    tick();
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL press_accept: got valid=%0b expected 0", ev_valid); end
    ev_ready = 1'b0;
  endtask

  task automatic test_ext_break();
    ev_ready = 1'b0;
    send(8'hE0, d, e);
    n_tests++; if (d !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL extbrk_e0: got done=%0b err=%0b expected 1/0", d, e); end
    send(8'hF0, d, e);
    n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL extbrk_f0_err: got %0b expected 0", e); end
    send(8'h75, d, e);
    n_tests++; if (d !== 1'b1) begin n_fail++; $display("FAIL extbrk_pop: got %0b expected 1", d); end
    n_tests++; if ({ev_valid, ev_code, ev_break, ev_ext} !== {1'b1, 8'h75, 1'b1, EXT})
      begin n_fail++; $display("FAIL extbrk_event: got v=%0b %0h/%0b/%0b expected 1 75/1/%0b", ev_valid, ev_code, ev_break, ev_ext, EXT); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL extbrk_accept: got %0b expected 0", ev_valid); end
  endtask

  task automatic test_timeout();
    int errs;
    ev_ready = 1'b0;
    send(8'hF0, d, e);
    errs = 0;
    repeat (TO - 1) begin if (err === 1'b1) errs++; tick(); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL timeout_early_err: got %0d pulses expected 0", errs); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %0b expected 1", err); end
    tick();
    errs = 0;
    repeat (5) begin if (err === 1'b1) errs++; tick(); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL timeout_extra_err: got %0d pulses expected 0", errs); end
    send(8'h1C, d, e);
    n_tests++; if ({ev_valid, ev_code, ev_break, ev_ext} !== {1'b1, 8'h1C, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL timeout_next_press: got v=%0b %0h/%0b/%0b expected 1 1c/0/0", ev_valid, ev_code, ev_break, ev_ext); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    // byte arriving exactly in the expiry cycle wins
    send(8'hF0, d, e);
    repeat (TO - 1) tick();
    send(8'h1C, d, e);
    n_tests++; if (d !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL timeout_race: got done=%0b err=%0b expected 1/0", d, e); end
    n_tests++; if ({ev_valid, ev_code, ev_break} !== {1'b1, 8'h1C, 1'b1})
      begin n_fail++; $display("FAIL timeout_race_event: got v=%0b %0h/%0b expected 1 1c/1", ev_valid, ev_code, ev_break); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    ev_ready = 1'b0;
    send(8'h1C, d, e);
    rx_rdy = 1'b1; rx_data = 8'h2A; #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rx_done !== 1'b0 || ev_valid !== 1'b1 || ev_code !== 8'h1C) bad++;
      @(posedge clk); #3;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
    ev_ready = 1'b1; #1;
    n_tests++; if (ev_valid !== 1'b1 || rx_done !== 1'b0) begin n_fail++; $display("FAIL bp_bubble: got valid=%0b done=%0b expected 1/0", ev_valid, rx_done); end
    @(posedge clk); #1; ev_ready = 1'b0; #1;
    n_tests++; if (rx_done !== 1'b1 || ev_valid !== 1'b0) begin n_fail++; $display("FAIL bp_next_pop: got done=%0b valid=%0b expected 1/0", rx_done, ev_valid); end
    @(posedge clk); #1; rx_rdy = 1'b0; #1;
    n_tests++; if ({ev_valid, ev_code, ev_break} !== {1'b1, 8'h2A, 1'b0})
      begin n_fail++; $display("FAIL bp_second_event: got v=%0b %0h/%0b expected 1 2a/0", ev_valid, ev_code, ev_break); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
  endtask

  task automatic test_violation();
    ev_ready = 1'b0;
    send(8'hF0, d, e);
    send(8'hE0, d, e);
    n_tests++; if (e !== EXT) begin n_fail++; $display("FAIL viol_e0_err: got %0b expected %0b", e, EXT); end
    send(8'h74, d, e);
    n_tests++; if ({ev_valid, ev_code, ev_break, ev_ext} !== {1'b1, 8'h74, ~EXT, EXT})
      begin n_fail++; $display("FAIL viol_event: got v=%0b %0h/%0b/%0b expected 1 74/%0b/%0b", ev_valid, ev_code, ev_break, ev_ext, ~EXT, EXT); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    send(8'hFF, d, e);
    n_tests++; if (d !== 1'b1 || e !== 1'b1) begin n_fail++; $display("FAIL viol_ff: got done=%0b err=%0b expected 1/1", d, e); end
    tick();
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL viol_ff_noevent: got %0b expected 0", ev_valid); end
    send(8'hF0, d, e);
    send(8'h00, d, e);
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL viol_00: got err=%0b expected 1", e); end
    send(8'h1C, d, e);
    n_tests++; if ({ev_valid, ev_code, ev_break} !== {1'b1, 8'h1C, 1'b0})
      begin n_fail++; $display("FAIL viol_00_recover: got v=%0b %0h/%0b expected 1 1c/0", ev_valid, ev_code, ev_break); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    ev_ready = 1'b0;
    send(8'hE0, d, e);
    rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'hFF; #1;
    n_tests++; if ({err, rx_done, ev_valid} !== 3'b000) begin n_fail++; $display("FAIL rstmid_outputs: got err/done/valid=%0b%0b%0b expected 000", err, rx_done, ev_valid); end
    @(posedge clk); #1; rst = 1'b0; rx_rdy = 1'b0; #1;
    n_tests++; if (ev_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got valid=%0b err=%0b expected 0/0", ev_valid, err); end
    send(8'h74, d, e);
    n_tests++; if ({ev_valid, ev_code, ev_break, ev_ext} !== {1'b1, 8'h74, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL rstmid_event: got v=%0b %0h/%0b/%0b expected 1 74/0/0", ev_valid, ev_code, ev_break, ev_ext); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++; if (ev_valid !== 1'b0 || ev_code !== 8'h00) begin n_fail++; $display("FAIL rsthold_drop: got valid=%0b code=%0h expected 0/00", ev_valid, ev_code); end
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(15);
    case (r)
      0, 1, 2: return 8'hE0;
      3, 4, 5: return 8'hF0;
      6:       return 8'h00;
      7:       return 8'hFF;
      default: return 8'($urandom_range(255));
    endcase
  endfunction

  task automatic test_random();
    logic [7:0] fifo[$];
    logic [7:0] b, m_code, e_code;
    logic m_hold, m_pe, m_pf, m_brk, m_ext;
    logic en, e_done, e_valid, e_err, e_brk, e_ext;
    int m_cnt, gap;
    rst = 1'b1; rx_rdy = 1'b0; ev_ready = 1'b0; tick(); rst = 1'b0;
    m_hold = 0; m_pe = 0; m_pf = 0; m_brk = 0; m_ext = 0; m_code = 8'h00; m_cnt = 0; gap = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (gap > 0) begin
        gap--; en = 1'b0;
      end else begin
        en = ($urandom_range(3) != 0);
        if ($urandom_range(59) == 0) gap = $urandom_range(50, 30);
      end
      while (fifo.size() < 4) fifo.push_back(rand_byte());
      rx_rdy = en;
      rx_data = en ? fifo[0] : 8'($urandom_range(255));
      ev_ready = ($urandom_range(2) != 0);
      #1;
      e_done = en && !m_hold; e_valid = m_hold; e_err = 1'b0;
      e_code = m_code; e_brk = m_brk; e_ext = m_ext;
      if (m_hold) begin
        if (ev_ready) m_hold = 1'b0;
      end else if (en) begin
        b = fifo[0]; m_cnt = 0;
        if (b == 8'h00 || b == 8'hFF) begin
          e_err = 1'b1; m_pe = 1'b0; m_pf = 1'b0;
        end else if (b == 8'hE0) begin
`ifdef PS2_EXT_EN
          e_err = m_pf; m_pe = 1'b1; m_pf = 1'b0;
`endif
        end else if (b == 8'hF0) begin
          if (m_pf) e_err = 1'b1;
          else      m_pf = 1'b1;
        end else begin
          m_hold = 1'b1; m_code = b; m_brk = m_pf; m_ext = m_pe; m_pe = 1'b0; m_pf = 1'b0;
        end
      end else if (m_pe || m_pf) begin
        if (m_cnt == TO - 1) begin
          e_err = 1'b1; m_pe = 1'b0; m_pf = 1'b0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      n_tests++; if (rx_done !== e_done)   begin n_fail++; $display("FAIL rand_rx_done cyc %0d: got %0b expected %0b", cyc, rx_done, e_done); end
      n_tests++; if (ev_valid !== e_valid) begin n_fail++; $display("FAIL rand_ev_valid cyc %0d: got %0b expected %0b", cyc, ev_valid, e_valid); end
      n_tests++; if (err !== e_err)        begin n_fail++; $display("FAIL rand_err cyc %0d: got %0b expected %0b", cyc, err, e_err); end
      n_tests++; if (ev_code !== e_code)   begin n_fail++; $display("FAIL rand_ev_code cyc %0d: got %0h expected %0h", cyc, ev_code, e_code); end
      n_tests++; if (ev_break !== e_brk)   begin n_fail++; $display("FAIL rand_ev_break cyc %0d: got %0b expected %0b", cyc, ev_break, e_brk); end
      n_tests++; if (ev_ext !== e_ext)     begin n_fail++; $display("FAIL rand_ev_ext cyc %0d: got %0b expected %0b", cyc, ev_ext, e_ext); end
      if (e_done) void'(fifo.pop_front());
      @(posedge clk); #2;
    end
    rx_rdy = 1'b0; ev_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_ext_break();
    test_timeout();
    test_backpressure();
    test_violation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scan_ctrl.md
PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 25000, meaning prefix-wait limit in clk cycles (1 ms at 25 MHz).
REQ-002 SHALL have parameter TW, default 16, meaning timeout counter width in bits (2^TW > TIMEOUT).
REQ-003 SHALL have port clk  input  1  meaning single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous, active-high.
REQ-005 SHALL have port rx_rdy  input  1  meaning PS/2 receiver FIFO non-empty.
REQ-006 SHALL have port rx_data  input  8  meaning receiver FIFO head byte, valid while rx_rdy=1.
REQ-007 SHALL have port rx_done  output  1  meaning pop strobe to the receiver FIFO.
REQ-008 SHALL have port ev_valid  output  1  meaning key event pending.
REQ-009 SHALL have port ev_ready  input  1  meaning consumer accepts the event.
REQ-010 SHALL have port ev_code  output  8  meaning scan code of the event.
REQ-011 SHALL have port ev_break  output  1  meaning 1 = key release (F0-prefixed), 0 = press.
REQ-012 SHALL have port ev_ext  output  1  meaning 1 = extended key (E0-prefixed).
REQ-013 SHALL have port err  output  1  meaning one-cycle error pulse.

Function
REQ-014 SHALL implement states IDLE, GOT_E0, GOT_F0, GOT_E0F0 and HOLD.
REQ-015 SHALL drive rx_done combinationally as rx_rdy & (state != HOLD), consuming rx_data in that same cycle.
REQ-016 SHALL, on a consumed byte in IDLE, go to GOT_E0 for 0xE0, to GOT_F0 for 0xF0, and otherwise to HOLD with code=byte, break=0, ext=0.
REQ-017 SHALL, on a consumed byte in GOT_E0, go to GOT_E0F0 for 0xF0, stay in GOT_E0 for 0xE0, and otherwise go to HOLD with ext=1, break=0.
REQ-018 SHALL, on a consumed non-prefix byte in GOT_F0, go to HOLD with break=1, ext=0, and in GOT_E0F0 go to HOLD with break=1, ext=1.
REQ-019 SHALL treat 0xE0 consumed in GOT_F0 or GOT_E0F0 as a sequence violation: pulse err and go to GOT_E0.
REQ-020 SHALL treat 0xF0 consumed in GOT_F0 or GOT_E0F0 as a sequence violation: pulse err and keep the state.
REQ-021 SHALL treat consumed bytes 0x00 and 0xFF (keyboard overrun/error) in any non-HOLD state as errors: discard the byte, pulse err and go to IDLE.
REQ-022 SHALL assert ev_valid exactly while in HOLD, with ev_code, ev_break and ev_ext held stable until the handshake completes.
REQ-023 SHALL leave HOLD for IDLE on the cycle ev_valid & ev_ready; no byte is consumed in that cycle (one-cycle bubble).
REQ-024 SHALL give a latency of one cycle from consuming the final byte of a sequence to ev_valid=1.
REQ-025 SHALL count cycles spent in GOT_E0, GOT_F0 or GOT_E0F0, clear the count on every consumed byte, and, when the count reaches TIMEOUT-1 with no byte consumed, pulse err and go to IDLE.
REQ-026 SHALL hold the timeout counter at 0 in IDLE and HOLD.
REQ-027 SHALL let a byte consumed in the same cycle as the timeout expiry take precedence; the counter clears and no err pulse occurs.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set state=IDLE, counter=0, ev_code=0x00, ev_break=0, ev_ext=0.
REQ-029 SHALL output rx_done=0, ev_valid=0 and err=0 while rst=1.
REQ-030 SHALL, when reset is asserted mid-sequence or in HOLD, discard the partial prefix or pending event without an err pulse.

Configuration
REQ-031 SHALL use macro PS2_EXT_EN; when defined, extended-key handling follows REQ-016 to REQ-019.
REQ-032 SHALL, when PS2_EXT_EN is undefined, omit GOT_E0 and GOT_E0F0, tie ev_ext to 0, and silently consume 0xE0 in every state with no state change and no err pulse.

Verification
REQ-033 SHALL cover: bytes 0x1C with ev_ready=1 -> one event {code 0x1C, break 0, ext 0}, ev_valid high one cycle after the pop.
REQ-034 SHALL cover: bytes E0,F0,75 -> single event {0x75, break 1, ext 1}; with PS2_EXT_EN undefined -> {0x75, break 1, ext 0}.
REQ-035 SHALL cover: F0 followed by no byte for TIMEOUT cycles -> err pulses exactly once and state returns to IDLE; a following 0x1C yields a press event.
REQ-036 SHALL cover: ev_ready=0 for 10 cycles with rx_rdy=1 -> rx_done stays 0 and the event is held; ev_ready=1 -> HOLD exits, then the next byte pops one cycle later.
REQ-037 SHALL cover: F0,E0,74 -> err pulse on E0, then event {0x74, break 0, ext 1}; byte 0xFF -> err pulse and no event.
REQ-038 SHALL cover: rst asserted after E0 is consumed -> no event, and a following 0x74 gives {0x74, break 0, ext 0}.
